// File: rtl/excess3_to_bcd_seq.sv
// Excess-3 to BCD receiver: collects Excess-3 digits MSD first, packs them into
// a DIGITS-wide BCD word and presents it on a registered valid/ready port.
module excess3_to_bcd_seq #(
  parameter  int DIGITS = 4,
  localparam int CW     = $clog2(DIGITS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            in_code,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic                  out_err,
  output logic [CW-1:0]         out_ndig
);

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  state_t                state_reg, state_next;
  logic [CW-1:0]         count_reg, count_next;
  logic [4*DIGITS-1:0]   shift_reg, shift_next;
  logic                  err_reg, err_next;
  logic [4*DIGITS-1:0]   out_bcd_reg, out_bcd_next;
  logic                  out_err_reg, out_err_next;
  logic [CW-1:0]         out_ndig_reg, out_ndig_next;

  logic                  accept;
  logic                  bad_code;
  logic [3:0]            digit;
  logic                  first_digit;
  logic [4*DIGITS-1:0]   shifted;
  logic [CW-1:0]         count_inc;
  logic                  closing;
  logic                  err_with_digit;

  assign in_ready  = (state_reg == COLLECT);
  assign out_valid = (state_reg == HOLD);
  assign out_bcd   = out_bcd_reg;
  assign out_err   = out_err_reg;
  assign out_ndig  = out_ndig_reg;

  assign accept      = in_valid & in_ready;
  assign bad_code    = (in_code < 4'h3) || (in_code > 4'hC);
  assign digit       = bad_code ? 4'hF : (in_code - 4'd3);
  assign first_digit = (count_reg == '0);
  assign count_inc   = count_reg + 1'b1;
  assign closing     = in_last || (count_inc == CW'(DIGITS));

  // A new word starts from a cleared shifter so short words come out right-justified.
  generate
    if (DIGITS == 1) begin : g_single
      assign shifted = digit;
    end else begin : g_multi
      logic [4*DIGITS-1:0] base;
      assign base    = first_digit ? '0 : shift_reg;
      assign shifted = {base[4*DIGITS-5:0], digit};
    end
  endgenerate

  assign err_with_digit = (first_digit ? 1'b0 : err_reg) | bad_code;

  always_comb begin
    state_next    = state_reg;
    count_next    = count_reg;
    shift_next    = shift_reg;
    err_next      = err_reg;
    out_bcd_next  = out_bcd_reg;
    out_err_next  = out_err_reg;
    out_ndig_next = out_ndig_reg;
    case (state_reg)
      COLLECT: begin
        if (accept) begin
          shift_next = shifted;
          err_next   = err_with_digit;
          count_next = count_inc;
          if (closing) begin
            out_bcd_next  = shifted;
            out_err_next  = err_with_digit;
            out_ndig_next = count_inc;
            state_next    = HOLD;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_next = COLLECT;
          count_next = '0;
          err_next   = 1'b0;
        end
      end
      default: state_next = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= COLLECT;
      count_reg    <= '0;
      shift_reg    <= '0;
      err_reg      <= 1'b0;
      out_bcd_reg  <= '0;
      out_err_reg  <= 1'b0;
      out_ndig_reg <= '0;
    end else begin
      state_reg    <= state_next;
      count_reg    <= count_next;
      shift_reg    <= shift_next;
      err_reg      <= err_next;
      out_bcd_reg  <= out_bcd_next;
      out_err_reg  <= out_err_next;
      out_ndig_reg <= out_ndig_next;
    end
  end

endmodule
